// File: rtl/uart_tx_arbiter.sv
// Shares one uarttx byte transmitter among NREQ requesters using send/ready handshakes.
// Round-robin arbitration by default; define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module uart_tx_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clock115200,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_ready
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state;
  logic [PW-1:0] win;
  logic          found;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Downward scan so the lowest set index is the last assignment and wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win   = PW'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] ptr;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from ptr upward, wrapping at NREQ, which may not be a power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clock115200 or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ack     <= '0;
      busy    <= 1'b0;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found && tx_ready) begin
            tx_data <= req_data[{win, 3'b000} +: 8];
            tx_send <= 1'b1;
            ack     <= NREQ'(1) << win;
            busy    <= 1'b1;
            state   <= START;
`ifndef UART_ARB_FIXED_PRIO_EN
            ptr     <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
          end
        end
        // tx_ready is still the pre-send value here, so it is not looked at.
        START: begin
          tx_send <= 1'b0;
          ack     <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uarttx model, directed cases and randomized
// requests checked against a winner-prediction model (honours UART_ARB_FIXED_PRIO_EN).
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;

  logic             clock115200 = 1'b0;
  logic             resetn = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]  ack;
  logic             busy;
  logic [7:0]       tx_data;
  logic             tx_send;
  logic             tx_ready;

  uart_tx_arbiter #(.NREQ(NREQ)) dut (
    .clock115200(clock115200), .resetn(resetn), .req(req), .req_data(req_data),
    .ack(ack), .busy(busy), .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready)
  );

  always #5 clock115200 = ~clock115200;

  // uarttx model: ready low one cycle after reset, ten bit periods per frame, LSB first.
  logic [9:0] u_frame;
  int         u_cnt;
  logic       u_active, line, line_valid;
  always @(posedge clock115200 or negedge resetn) begin
    if (!resetn) begin
      tx_ready <= 1'b0; u_active <= 1'b0; u_cnt <= 0; line <= 1'b1; line_valid <= 1'b0;
      u_frame <= '1;
    end else begin
      line_valid <= u_active;
      if (u_active) begin
        line  <= u_frame[u_cnt];
        u_cnt <= u_cnt + 1;
        if (u_cnt == 9) begin
          u_active <= 1'b0;
          tx_ready <= 1'b1;
        end
      end else begin
        line <= 1'b1;
        if (!tx_ready) tx_ready <= 1'b1;
        else if (tx_send) begin
          u_frame  <= {1'b1, tx_data, 1'b0};
          u_cnt    <= 0;
          u_active <= 1'b1;
          tx_ready <= 1'b0;
        end
      end
    end
  end

  int   tests = 0, fails = 0;
  int   cyc = 0, last_send = -1, send_cnt = 0;
  int   viol_onehot = 0, viol_acksend = 0, viol_stable = 0, viol_gap = 0;
  int   ptr_m = 0, last_w = 0;
  bit   granted;
  logic [7:0] latched = 8'h00;
  logic line_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [NREQ-1:0] r, input int p);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  // One clock: predict from the inputs seen at the posedge, then check at the negedge.
  task automatic step();
    logic [NREQ-1:0]   rq;
    logic [8*NREQ-1:0] rd;
    bit exp_send;
    int w;
    rq = req; rd = req_data;
    exp_send = resetn && !busy && tx_ready && (rq != '0);
    @(negedge clock115200);
    cyc++;
    granted = 1'b0;
    if ($countones(ack) > 1) viol_onehot++;
    if ((ack != '0) != tx_send) viol_acksend++;
    if (tx_send) begin
      send_cnt++;
      if (last_send >= 0 && cyc - last_send < 12) viol_gap++;
      last_send = cyc;
      latched = tx_data;
    end else if (busy && tx_data !== latched) viol_stable++;
    if (line_valid) line_q.push_back(line);
    if (exp_send || tx_send) begin
      chk("send", {31'd0, tx_send}, {31'd0, exp_send});
      if (exp_send) begin
        w = winner(rq, ptr_m);
        chk("ack", {28'd0, ack}, 32'(1) << w);
        chk("data", {24'd0, tx_data}, {24'd0, rd[8*w +: 8]});
        ptr_m = (w + 1) % NREQ;
        last_w = w;
        granted = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    @(negedge clock115200);
    @(negedge clock115200);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_send", {31'd0, tx_send}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    ptr_m = 0; last_send = -1; latched = 8'h00;
    line_q.delete();
    resetn = 1'b1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    do begin step(); n++; end while (!granted && n < 60);
    chk(tag, {31'd0, granted}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin step(); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    logic [9:0] lb;
    int sends0;

    // Single byte A5 requested in the first cycle after reset.
    req_data[7:0] = 8'hA5;
    do_reset();
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    sends0 = send_cnt;
    step();
    chk("startup_hold", {31'd0, tx_send}, 32'd0);
    step();
    chk("startup_send", {31'd0, tx_send}, 32'd1);
    if (granted) req = '0;
    wait_idle("a5_idle");
    lb = '1;
    for (int i = 0; i < 10; i++) if (i < line_q.size()) lb[i] = line_q[i];
    chk("line_len", line_q.size(), 32'd10);
    chk("line_bits", {22'd0, lb}, {22'd0, 1'b1, 8'hA5, 1'b0});
    repeat (3) step();
    chk("a5_one_frame", send_cnt - sends0, 32'd1);

    // All four requesting and held.
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    sends0 = send_cnt;
    for (int n = 0; n < 300 && order.size() < 5; n++) begin
      step();
      if (granted) order.push_back(last_w);
    end
    req = '0;
    wait_idle("all_idle");
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("all_count", order.size(), 32'd5);
    for (int i = 0; i < 5; i++) if (i < order.size()) chk("all_order", order[i], exp_order[i]);
    chk("all_sends", send_cnt - sends0, 32'd5);

    // Data change while the frame is awaited.
    do_reset();
    req_data[7:0] = 8'h55;
    req = 4'b0001;
    wait_grant("hold_grant");
    req = '0;
    for (int n = 0; n < 20 && tx_ready; n++) step();
    step();
    req_data[7:0] = 8'hFF;
    for (int n = 0; n < 40 && busy; n++) begin
      step();
      if (busy) chk("hold_data", {24'd0, tx_data}, 32'h55);
    end
    chk("hold_idle", {31'd0, busy}, 32'd0);

    // Reset pulsed mid-frame; ptr must restart from 0.
    do_reset();
    req_data = {8'h99, 8'h00, 8'h3C, 8'h77};
    req = 4'b0010;
    wait_grant("mid_grant");
    req = '0;
    repeat (5) step();
    #2 resetn = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_data", {24'd0, tx_data}, 32'd0);
    chk("async_send", {31'd0, tx_send}, 32'd0);
    chk("async_ack", {28'd0, ack}, 32'd0);
    @(negedge clock115200);
    ptr_m = 0; last_send = -1; latched = 8'h00;
    resetn = 1'b1;
    req = 4'b0101;
    wait_grant("post_rst_grant");
    chk("post_rst_winner", last_w, 32'd0);
    req = '0;
    wait_idle("post_rst_idle");
    req = 4'b0100;
    wait_grant("req2_grant");
    chk("req2_winner", last_w, 32'd2);
    req = '0;
    wait_idle("req2_idle");

    // Randomized requests, withdrawals and re-requests.
    do_reset();
    sends0 = send_cnt;
    for (int n = 0; n < 2000; n++) begin
      step();
      if (granted) begin
        if ($urandom % 2 == 0) req[last_w] = 1'b0;
        else req_data[8*last_w +: 8] = 8'($urandom);
      end else if ($urandom % 6 == 0) begin
        int i;
        i = int'($urandom % NREQ);
        if (req[i]) req[i] = 1'b0;
        else begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    req = '0;
    wait_idle("rand_idle");
    chk("rand_activity", {31'd0, (send_cnt - sends0) > 20}, 32'd1);

    chk("ack_onehot", viol_onehot, 32'd0);
    chk("ack_with_send", viol_acksend, 32'd0);
    chk("data_stable", viol_stable, 32'd0);
    chk("send_gap", viol_gap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
